fifo_uart_drain: RTL and testbench

Read-side controller for the sniffer's synchronous BRAM FIFO. It drains captured bytes from the FIFO read port into a local burst buffer, frames them as packets (sync, length, payload, checksum), and sequences them byte by byte into the UART transmitter through a start/busy handshake. It sits between the FIFO and the UART TX. It is the only agent that drives the FIFO `rd_en`.

---
 rtl/fifo_uart_drain_pkg.sv | 22 ++
 rtl/fifo_uart_drain_burst_buf.sv | 41 ++++
 rtl/fifo_uart_drain.sv | 178 +++++++++++++++++
 tb/tb_fifo_uart_drain.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain controller: state encoding,
// default sync byte and the fixed per-packet framing overhead.
package fifo_uart_drain_pkg;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_FILL_ENC     = 2'd1;
    localparam logic [1:0] ST_TX_ISSUE_ENC = 2'd2;
    localparam logic [1:0] ST_TX_WAIT_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_FILL     = ST_FILL_ENC,
        ST_TX_ISSUE = ST_TX_ISSUE_ENC,
        ST_TX_WAIT  = ST_TX_WAIT_ENC
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // SYNC + LEN + CHK
    localparam int PKT_OVERHEAD = 3;

endpackage

// File: rtl/fifo_uart_drain_burst_buf.sv
// Burst buffer: DEPTH x 8 register file, written while filling from the FIFO
// and read by packet byte index while transmitting.
module drain_burst_buf
    import fifo_uart_drain_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic       wr_ok;

    assign wr_ok = wr_en && (wr_addr < DEPTH_B);

    always_comb begin
        // NOTE: start from the held value so every path assigns mem_d and no latch is inferred.
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr[AW-1:0]] = wr_data;
        end
    end

    // NOTE: storage is deliberately not reset; the controller clears cnt, so stale entries are never read.
    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = (rd_addr < DEPTH_B) ? mem_q[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains the capture FIFO in bursts and frames each burst as
// SYNC, LEN, payload, CHK bytes sent one at a time through the UART start/busy handshake.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int         MAX_BURST     = 16,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int         FLUSH_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    input  logic        fifo_almost_empty,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam int                 TIMER_W   = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FLUSH_TIMEOUT);
    localparam logic [7:0]         BURST_MAX = 8'(MAX_BURST);
    localparam logic [8:0]         LAST_OFS  = 9'(PKT_OVERHEAD - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         chk_q, chk_d;
    logic               wait_arm_q, wait_arm_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic       buf_wr_en;
    logic [7:0] buf_rd_addr;
    logic [7:0] buf_rd_data;
    logic [7:0] cur_byte;
    logic       is_last;

    drain_burst_buf #(
        .DEPTH (MAX_BURST)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (cnt_q),
        .wr_data (fifo_rd_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    // idx spans 0..len+2 in 8 bits, so MAX_BURST above 253 would need a wider idx.
    assign is_last     = ({1'b0, idx_q} == ({1'b0, len_q} + LAST_OFS));
    assign buf_rd_addr = idx_q - 8'd2;

    always_comb begin
        if (idx_q == 8'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (idx_q == 8'd1) begin
            cur_byte = len_q;
        end else if (is_last) begin
            cur_byte = chk_q;
        end else begin
            cur_byte = buf_rd_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        cnt_d       = cnt_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        wait_arm_d  = 1'b0;
        tx_data_d   = tx_data_q;
        pkt_count_d = pkt_count_q;
        fifo_rd_en  = 1'b0;
        tx_start    = 1'b0;
        buf_wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && fifo_almost_empty) begin
                    timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
                end
                if (enable && !fifo_empty && (!fifo_almost_empty || timer_q == TIMER_MAX)) begin
                    state_d = ST_FILL;
                    timer_d = '0;
                end
            end

            ST_FILL: begin
                if (!fifo_empty && cnt_q < BURST_MAX) begin
                    fifo_rd_en = 1'b1;
                    buf_wr_en  = 1'b1;
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == BURST_MAX) begin
                        state_d = ST_TX_ISSUE;
                        len_d   = cnt_q + 8'd1;
                        idx_d   = 8'd0;
                    end
                end else if (cnt_q != 8'd0) begin
                    state_d = ST_TX_ISSUE;
                    len_d   = cnt_q;
                    idx_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data_d  = cur_byte;
                    wait_arm_d = 1'b1;
                    state_d    = ST_TX_WAIT;
                    // Checksum folds LEN and every payload byte as it goes out.
                    if (is_last) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else if (idx_q == 8'd0) begin
                        chk_d = 8'h00;
                    end else begin
                        chk_d = chk_q ^ cur_byte;
                    end
                end
            end

            ST_TX_WAIT: begin
                // The UART raises busy one cycle late, so the first WAIT cycle is blind.
                if (!wait_arm_q && !tx_busy) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_TX_ISSUE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            chk_q       <= 8'd0;
            wait_arm_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            wait_arm_q  <= wait_arm_d;
            tx_data_q   <= tx_data_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign tx_data   = tx_start ? cur_byte : tx_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: table of packet scenarios plus
// hand-written reset, backpressure and enable-drop sequences.
module tb_fifo_uart_drain;

    localparam int MAX_BURST = 16;
    localparam int FLUSH_TO  = 32;
    localparam int UART_BUSY = 10;
    localparam int AE_LEVEL  = 16;

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        int         exp_len;
        logic [7:0] exp_chk;
        int         exp_pop;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic        tx_hold = 1'b0;
    logic        fifo_rd_en, tx_start, busy;
    logic        fifo_empty, fifo_almost_empty, tx_busy;
    logic [7:0]  fifo_rd_data, tx_data;
    logic [15:0] pkt_count;

    logic [7:0] fifo_mem [256];
    int         wr_ptr   = 0;
    int         rd_ptr   = 0;
    int         n_pop    = 0;
    int         uart_cnt = 0;
    int         n_tx     = 0;
    logic [7:0] tx_log [4096];
    int         viol     = 0;
    logic       prev_start = 1'b0;
    logic       have_data  = 1'b0;
    logic [7:0] last_data  = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty        = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) <= AE_LEVEL);
    assign fifo_rd_data      = fifo_mem[rd_ptr[7:0]];
    assign tx_busy           = (uart_cnt != 0) || tx_hold;

    fifo_uart_drain #(
        .MAX_BURST     (MAX_BURST),
        .SYNC_BYTE     (8'hA5),
        .FLUSH_TIMEOUT (FLUSH_TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .tx_busy           (tx_busy),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    // FIFO pop side, UART model and protocol monitors.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            rd_ptr <= rd_ptr + 1;
            n_pop  <= n_pop + 1;
        end
        if (tx_start) begin
            tx_log[n_tx[11:0]] <= tx_data;
            n_tx     <= n_tx + 1;
            uart_cnt <= UART_BUSY;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
        end
        if (!rst && ((fifo_rd_en && fifo_empty) || (fifo_rd_en && tx_start) ||
                     (tx_start && prev_start) || (!tx_start && have_data && tx_data != last_data))) begin
            viol <= viol + 1;
        end
        prev_start <= tx_start && !rst;
        if (rst) begin
            have_data <= 1'b0;
        end else if (tx_start) begin
            have_data <= 1'b1;
            last_data <= tx_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input logic [7:0] b, input logic [7:0] s, input int i);
        return b + 8'(i) * s;
    endfunction

    task automatic push_seq(input int n, input logic [7:0] b, input logic [7:0] s);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = pbyte(b, s, i);
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        tx_hold = 1'b0;
        wr_ptr  = rd_ptr;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Returns the cycle of the first pop (counted from the current negedge) and the pop run length.
    task automatic run_pops(output int pop_k, output int run);
        pop_k = -1;
        run   = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                pop_k = k;
                break;
            end
        end
        while (fifo_rd_en && run < 300) begin
            run++;
            @(negedge clk);
        end
    endtask

    task automatic wait_tx(input int target, input int budget, input string nm);
        int k = 0;
        while (n_tx < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_tx < target) check({nm, "_timeout"}, n_tx, target);
    endtask

    task automatic check_packet(input string nm, input int at, input int len,
                                input logic [7:0] b, input logic [7:0] s, input logic [7:0] chk);
        check({nm, "_sync"}, tx_log[at], 8'hA5);
        check({nm, "_len"}, tx_log[at+1], 8'(len));
        for (int i = 0; i < len; i++) begin
            check({nm, "_payload"}, tx_log[at+2+i], pbyte(b, s, i));
        end
        check({nm, "_chk"}, tx_log[at+2+len], chk);
    endtask

    initial begin
        vec_t vecs[6];
        int   pop_k, run, base, pbase, hold_bad;

        vecs[0] = '{n: 20, base: 8'h40, step: 8'h01, exp_len: 16, exp_chk: 8'h10, exp_pop: 1};
        vecs[1] = '{n: 3,  base: 8'h11, step: 8'h11, exp_len: 3,  exp_chk: 8'h03, exp_pop: 33};
        vecs[2] = '{n: 1,  base: 8'h7E, step: 8'h00, exp_len: 1,  exp_chk: 8'h7F, exp_pop: 33};
        vecs[3] = '{n: 5,  base: 8'hFF, step: 8'h00, exp_len: 5,  exp_chk: 8'hFA, exp_pop: 33};
        vecs[4] = '{n: 18, base: 8'h01, step: 8'h01, exp_len: 16, exp_chk: 8'h00, exp_pop: 1};
        vecs[5] = '{n: 2,  base: 8'h0F, step: 8'hF0, exp_len: 2,  exp_chk: 8'hF2, exp_pop: 33};

        enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_tx_data", tx_data, 8'h00);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            base  = n_tx;
            pbase = n_pop;
            push_seq(vecs[v].n, vecs[v].base, vecs[v].step);
            run_pops(pop_k, run);
            check("vec_first_pop_cycle", pop_k, vecs[v].exp_pop);
            check("vec_pop_run", run, vecs[v].exp_len);
            if (vecs[v].exp_len == MAX_BURST) check("vec_sync_latency", tx_start, 1);
            wait_tx(base + vecs[v].exp_len + 3, 600, "vec_stream");
            @(negedge clk);
            check("vec_pkt_count", pkt_count, 1);
            check("vec_total_pops", n_pop - pbase, vecs[v].exp_len);
            check_packet("vec", base, vecs[v].exp_len, vecs[v].base, vecs[v].step, vecs[v].exp_chk);
        end

        // Full bursts from a 60-byte FIFO, then reset in TX_WAIT of byte 7 of the second packet.
        do_reset();
        base  = n_tx;
        push_seq(60, 8'h00, 8'h01);
        run_pops(pop_k, run);
        check("full_first_pop", pop_k, 1);
        check("full_pop_run", run, 16);
        wait_tx(base + 19, 600, "full_stream");
        @(negedge clk);
        check("full_pkt_count", pkt_count, 1);
        check_packet("full", base, 16, 8'h00, 8'h01, 8'h10);
        wait_tx(base + 27, 600, "abort_stream");
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_tx_data", tx_data, 8'h00);
        rst   = 1'b0;
        base  = n_tx;
        pbase = n_pop;
        repeat (30) @(negedge clk);
        check("rst_no_tx_after", n_tx - base, 0);
        check("rst_no_pop_disabled", n_pop - pbase, 0);
        enable = 1'b1;
        run_pops(pop_k, run);
        check("rst_next_first_pop", pop_k, 1);
        check("rst_next_pop_run", run, 16);
        wait_tx(base + 19, 600, "rst_next_stream");
        @(negedge clk);
        check("rst_next_pkt_count", pkt_count, 1);
        check_packet("rst_next", base, 16, 8'h20, 8'h01, 8'h10);

        // Backpressure after the LEN byte.
        do_reset();
        base = n_tx;
        push_seq(20, 8'hC0, 8'h01);
        wait_tx(base + 2, 600, "bp_len");
        tx_hold  = 1'b1;
        hold_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_start) hold_bad++;
        end
        check("bp_no_start_in_hold", hold_bad, 0);
        tx_hold = 1'b0;
        @(negedge clk);
        check("bp_resume_start", tx_start, 1);
        check("bp_resume_data", tx_data, 8'hC0);
        wait_tx(base + 19, 600, "bp_stream");
        check_packet("bp", base, 16, 8'hC0, 8'h01, 8'h10);

        // Enable dropped during payload byte 5 with 40 bytes still queued.
        do_reset();
        base  = n_tx;
        pbase = n_pop;
        push_seq(56, 8'h30, 8'h01);
        wait_tx(base + 8, 600, "en_byte5");
        enable = 1'b0;
        wait_tx(base + 19, 600, "en_stream");
        check_packet("en", base, 16, 8'h30, 8'h01, 8'h10);
        repeat (60) @(negedge clk);
        check("en_busy_low", busy, 0);
        check("en_no_more_pops", n_pop - pbase, 16);
        check("en_no_more_tx", n_tx - base, 19);

        check("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
